cu_pipe_ctrl: RTL and testbench
===============================

// Module: cu_pipe_ctrl
// PURPOSE
//  Registered, handshaked instruction decode/control unit; next-generation CU for the pipelined core.
//  - Decodes a full 32-bit instruction into the datapath control bundle plus an illegal-instruction flag.
//  - Presents the result through a valid/ready output register with backpressure.
//  - Tracks multi-cycle MULT/DIV occupancy and stalls dependent HI/LO instructions.
//  - Sits between the fetch stage (upstream) and the execute stage (downstream).
// PARAMETERS
//  ALUC_W      5  alu_control width (>=5); `defines.v codes zero-extended to this width
//  MUL_CYCLES  4  MULT/MULTU occupancy in cycles (>=1)
//  DIV_CYCLES  8  DIV/DIVU occupancy in cycles (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  in_valid     in   1       instr is valid
//  in_ready     out  1       unit accepts instr this cycle
//  instr        in   32      instruction; opcode = [31:26], func = [5:0]
//  out_valid    out  1       control bundle valid
//  out_ready    in   1       downstream accepts the bundle
//  alu_control  out  ALUC_W  ALU operation code
//  alusrc_b, regdst, memwrite, memread, branch, jump, memtoreg, regwrite
//               out  1 each  datapath controls
//  hilo_write   out  1       bundle is MULT/MULTU/DIV/DIVU
//  illegal      out  1       opcode/func not decoded
//  md_busy      out  1       multiply/divide unit occupied
// BEHAVIOUR
//  Reset (async, any cycle, including mid-BUSY):
//    - all outputs 0 except in_ready; state IDLE, counter 0.
//    - in_ready=1 on the first cycle after reset is released.
//  Decode classes:
//    - R-type: opcode 000000.
//    - Load 100xxx, store 101xxx, arith-imm 001xxx, branch 0001xx, jump 00001x.
//    - Anything else (e.g. 000001, 01xxxx, 11xxxx) is illegal.
//  Control bundle:
//    - regdst = R-type.
//    - alusrc_b = load | store | arith-imm.
//    - memtoreg = memread = load; memwrite = store.
//    - branch = branch class; jump = jump class.
//    - regwrite = (R-type & !hilo_write) | load | arith-imm.
//  alu_control:
//    - Load/store: `ADD. Branch: `SUB.
//    - Arith-imm: ADDI/ADDIU `ADD; SLTI/SLTIU `SLT; ANDI `AND; ORI `OR; XORI `XOR; LUI `LUI.
//    - R-type func map: SLL/SLLV `SLL; SRL/SRLV `SRL; SRA/SRAV `SRA; MFHI; MFLO;
//      MULT `MUL; MULTU `MULU; DIV; DIVU; ADD/ADDU `ADD; SUB/SUBU `SUB; AND; OR; XOR; NOR; SLT; SLTU.
//  Illegal instruction:
//    - Includes an unmapped R-type func.
//    - illegal=1, all enable outputs 0, alu_control=`ADD; still handshaked through normally.
//  Handshake:
//    - accept = in_valid & in_ready.
//    - in_ready = (!out_valid | out_ready) & !(md_busy & hz).
//    - hz = instr is MFHI, MFLO, MULT, MULTU, DIV or DIVU.
//    - On accept: the bundle is registered; out_valid=1 the next cycle (latency 1).
//    - out_valid & out_ready & !accept -> out_valid=0 next cycle.
//    - Accept and drain in the same cycle -> new bundle, out_valid stays 1 (full throughput).
//    - While out_valid & !out_ready, every output bit holds stable.
//  MD FSM (IDLE, BUSY), counter width clog2(max(MUL_CYCLES, DIV_CYCLES)+1):
//    - Accept of a mul/div with N cycles: N>1 -> state BUSY, cnt=N-1; N=1 -> stay IDLE.
//    - In BUSY: cnt==1 -> IDLE, cnt=0; otherwise cnt-1.
//    - md_busy = (state==BUSY).
//    - For a mul/div accepted in cycle t: md_busy is high in cycles t+1..t+N-1; a dependent instruction is accepted no earlier than t+N.
//    - Independent instructions are never stalled by BUSY.
//    - A second mul/div cannot overlap (it is stalled by hz).
//    - Output backpressure does not pause the counter.
// TESTING
//  T1: reset pulse while BUSY (DIV, cnt=5) -> all outputs 0, md_busy=0; in_ready=1 the cycle after release.
//  T2: instr=0x20010005 (ADDI), out_ready=1 -> next cycle out_valid=1, alusrc_b=1, regwrite=1, regdst=0, alu_control=`ADD, illegal=0.
//  T3: out_ready=0; send LW 0x8C220004 then SW 0xAC220008.
//      -> LW bundle held stable (memread=1, memtoreg=1); in_ready=0.
//      -> SW accepted in the cycle out_ready=1; out_valid stays 1.
//  T4: MUL_CYCLES=4; MULT (func 011000), then ADD, then MFLO.
//      -> ADD accepted without a stall; md_busy=1 for 3 cycles.
//      -> MFLO in_ready=0 until md_busy falls, then accepted.
//      -> MULT bundle: hilo_write=1, regwrite=0.
//  T5: instr=0x04000000 and R-type func 000001 -> illegal=1, all enables 0, alu_control=`ADD.
//  T6: DIV_CYCLES=1; DIV then MFHI back-to-back -> md_busy never 1, no stall.

Source files
------------

// File: rtl/cu_pipe_ctrl_if.sv
// cu_pipe_ctrl_if: fetch-side instruction handshake and execute-side control
// bundle of the pipelined control unit, bundled into one port.
interface cu_pipe_ctrl_if #(
  parameter int ALUC_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic              out_valid;
  logic              out_ready;
  logic [ALUC_W-1:0] alu_control;
  logic              alusrc_b;
  logic              regdst;
  logic              memwrite;
  logic              memread;
  logic              branch;
  logic              jump;
  logic              memtoreg;
  logic              regwrite;
  logic              hilo_write;
  logic              illegal;
  logic              md_busy;

  // Environment side: supplies instructions and downstream backpressure.
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_control, alusrc_b, regdst, memwrite,
           memread, branch, jump, memtoreg, regwrite, hilo_write, illegal,
           md_busy
  );

  // Control-unit side.
  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_control, alusrc_b, regdst, memwrite,
           memread, branch, jump, memtoreg, regwrite, hilo_write, illegal,
           md_busy
  );
endinterface

// File: rtl/cu_pipe_ctrl.sv
// cu_pipe_ctrl: registered instruction decoder with a valid/ready output
// stage and a multiply/divide occupancy tracker that stalls HI/LO users.
module cu_pipe_ctrl #(
  parameter int ALUC_W     = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input logic          clk,
  input logic          reset,
  cu_pipe_ctrl_if.slave bus
);

  localparam int MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;
  localparam logic [4:0] ALU_MUL  = 5'd12;
  localparam logic [4:0] ALU_MULU = 5'd13;
  localparam logic [4:0] ALU_DIV  = 5'd14;
  localparam logic [4:0] ALU_DIVU = 5'd15;
  localparam logic [4:0] ALU_MFHI = 5'd16;
  localparam logic [4:0] ALU_MFLO = 5'd17;

  typedef enum logic {IDLE, BUSY} md_state_e;

  typedef struct packed {
    logic [ALUC_W-1:0] alu_control;
    logic              alusrc_b;
    logic              regdst;
    logic              memwrite;
    logic              memread;
    logic              branch;
    logic              jump;
    logic              memtoreg;
    logic              regwrite;
    logic              hilo_write;
    logic              illegal;
  } bundle_t;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             instr_unused;
  logic             is_rtype;
  logic             is_mul;
  logic             is_div;
  logic             is_hz;
  logic             md_busy;
  logic             in_ready;
  logic             accept;
  bundle_t          dec;
  bundle_t          bundle_d;
  bundle_t          bundle_q;
  logic             out_valid_d;
  logic             out_valid_q;
  md_state_e        state_d;
  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  assign opcode       = bus.instr[31:26];
  assign funct        = bus.instr[5:0];
  assign instr_unused = ^bus.instr[25:6];

  assign is_rtype = (opcode == 6'b000000);
  assign is_mul   = is_rtype && ((funct == 6'b011000) || (funct == 6'b011001));
  assign is_div   = is_rtype && ((funct == 6'b011010) || (funct == 6'b011011));
  assign is_hz    = is_mul || is_div ||
                    (is_rtype && ((funct == 6'b010000) || (funct == 6'b010010)));

  // HI/LO users wait for the multiply/divide unit; everything else flows.
  assign md_busy  = (state_q == BUSY);
  assign in_ready = (!out_valid_q || bus.out_ready) && !(md_busy && is_hz);
  assign accept   = bus.in_valid && in_ready;

  // Decode the incoming instruction into a control bundle; illegal ones collapse to a bare flag.
  always_comb begin
    dec = '0;
    dec.alu_control = ALUC_W'(ALU_ADD);
    if (is_rtype) begin
      dec.regdst     = 1'b1;
      dec.hilo_write = is_mul || is_div;
      dec.regwrite   = !(is_mul || is_div);
      case (funct)
        6'b000000, 6'b000100: dec.alu_control = ALUC_W'(ALU_SLL);
        6'b000010, 6'b000110: dec.alu_control = ALUC_W'(ALU_SRL);
        6'b000011, 6'b000111: dec.alu_control = ALUC_W'(ALU_SRA);
        6'b010000:            dec.alu_control = ALUC_W'(ALU_MFHI);
        6'b010010:            dec.alu_control = ALUC_W'(ALU_MFLO);
        6'b011000:            dec.alu_control = ALUC_W'(ALU_MUL);
        6'b011001:            dec.alu_control = ALUC_W'(ALU_MULU);
        6'b011010:            dec.alu_control = ALUC_W'(ALU_DIV);
        6'b011011:            dec.alu_control = ALUC_W'(ALU_DIVU);
        6'b100000, 6'b100001: dec.alu_control = ALUC_W'(ALU_ADD);
        6'b100010, 6'b100011: dec.alu_control = ALUC_W'(ALU_SUB);
        6'b100100:            dec.alu_control = ALUC_W'(ALU_AND);
        6'b100101:            dec.alu_control = ALUC_W'(ALU_OR);
        6'b100110:            dec.alu_control = ALUC_W'(ALU_XOR);
        6'b100111:            dec.alu_control = ALUC_W'(ALU_NOR);
        6'b101010:            dec.alu_control = ALUC_W'(ALU_SLT);
        6'b101011:            dec.alu_control = ALUC_W'(ALU_SLTU);
        default:              dec.illegal     = 1'b1;
      endcase
    end else begin
      case (opcode[5:3])
        3'b100: begin
          dec.alusrc_b = 1'b1;
          dec.memread  = 1'b1;
          dec.memtoreg = 1'b1;
          dec.regwrite = 1'b1;
        end
        3'b101: begin
          dec.alusrc_b = 1'b1;
          dec.memwrite = 1'b1;
        end
        3'b001: begin
          dec.alusrc_b = 1'b1;
          dec.regwrite = 1'b1;
          case (opcode[2:0])
            3'b000, 3'b001: dec.alu_control = ALUC_W'(ALU_ADD);
            3'b010, 3'b011: dec.alu_control = ALUC_W'(ALU_SLT);
            3'b100:         dec.alu_control = ALUC_W'(ALU_AND);
            3'b101:         dec.alu_control = ALUC_W'(ALU_OR);
            3'b110:         dec.alu_control = ALUC_W'(ALU_XOR);
            default:        dec.alu_control = ALUC_W'(ALU_LUI);
          endcase
        end
        3'b000: begin
          if (opcode[2]) begin
            dec.branch      = 1'b1;
            dec.alu_control = ALUC_W'(ALU_SUB);
          end else if (opcode[1]) begin
            dec.jump = 1'b1;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    if (dec.illegal) begin
      dec             = '0;
      dec.illegal     = 1'b1;
      dec.alu_control = ALUC_W'(ALU_ADD);
    end
  end

  // Output stage: load on accept, drop valid once drained, otherwise hold everything.
  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      bundle_d    = dec;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Occupancy tracker: arm on an accepted mul/div longer than one cycle, count down freely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mul && (MUL_CYCLES > 1)) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
        end else if (accept && is_div && (DIV_CYCLES > 1)) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.md_busy     = md_busy;
  assign bus.alu_control = bundle_q.alu_control;
  assign bus.alusrc_b    = bundle_q.alusrc_b;
  assign bus.regdst      = bundle_q.regdst;
  assign bus.memwrite    = bundle_q.memwrite;
  assign bus.memread     = bundle_q.memread;
  assign bus.branch      = bundle_q.branch;
  assign bus.jump        = bundle_q.jump;
  assign bus.memtoreg    = bundle_q.memtoreg;
  assign bus.regwrite    = bundle_q.regwrite;
  assign bus.hilo_write  = bundle_q.hilo_write;
  assign bus.illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_cu_pipe_ctrl.sv
// tb_cu_pipe_ctrl: random and directed stimulus for cu_pipe_ctrl, checked
// against a decode-table and timestamp model of the control unit.
module tb_cu_pipe_ctrl;

  localparam int ALUC_W = 5;
  localparam int MUL_N  = 4;
  localparam int DIV_N  = 8;

  localparam int A_ADD = 0,  A_SUB = 1,  A_AND = 2,  A_OR = 3,   A_XOR = 4,  A_NOR = 5;
  localparam int A_SLT = 6,  A_SLTU = 7, A_SLL = 8,  A_SRL = 9,  A_SRA = 10, A_LUI = 11;
  localparam int A_MUL = 12, A_MULU = 13, A_DIV = 14, A_DIVU = 15, A_MFHI = 16, A_MFLO = 17;

  localparam logic [31:0] I_ADDI = 32'h20010005;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220008;
  localparam logic [31:0] I_MULT = 32'h00430018;
  localparam logic [31:0] I_DIV  = 32'h0043001A;
  localparam logic [31:0] I_ADD  = 32'h00430820;
  localparam logic [31:0] I_MFLO = 32'h00001012;
  localparam logic [31:0] I_MFHI = 32'h00001010;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cu_pipe_ctrl_if #(.ALUC_W(ALUC_W)) bus ();
  cu_pipe_ctrl_if #(.ALUC_W(ALUC_W)) bus_f ();

  cu_pipe_ctrl #(.ALUC_W(ALUC_W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cu_pipe_ctrl #(.ALUC_W(ALUC_W), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        m_ov;
  logic [14:0] m_bundle;
  int          md_start;
  int          md_n;

  function automatic int r_code(input logic [5:0] fn);
    case (fn)
      6'd0, 6'd4:   return A_SLL;
      6'd2, 6'd6:   return A_SRL;
      6'd3, 6'd7:   return A_SRA;
      6'd16:        return A_MFHI;
      6'd18:        return A_MFLO;
      6'd24:        return A_MUL;
      6'd25:        return A_MULU;
      6'd26:        return A_DIV;
      6'd27:        return A_DIVU;
      6'd32, 6'd33: return A_ADD;
      6'd34, 6'd35: return A_SUB;
      6'd36:        return A_AND;
      6'd37:        return A_OR;
      6'd38:        return A_XOR;
      6'd39:        return A_NOR;
      6'd42:        return A_SLT;
      6'd43:        return A_SLTU;
      default:      return -1;
    endcase
  endfunction

  function automatic int i_code(input logic [2:0] sel);
    case (sel)
      3'd0, 3'd1: return A_ADD;
      3'd2, 3'd3: return A_SLT;
      3'd4:       return A_AND;
      3'd5:       return A_OR;
      3'd6:       return A_XOR;
      default:    return A_LUI;
    endcase
  endfunction

  function automatic bit is_md(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] >= 6'd24) && (ins[5:0] <= 6'd27);
  endfunction

  function automatic bit is_hz(input logic [31:0] ins);
    return is_md(ins) ||
           ((ins[31:26] == 6'd0) && ((ins[5:0] == 6'd16) || (ins[5:0] == 6'd18)));
  endfunction

  // Expected bundle order: alu_control, alusrc_b, regdst, memwrite, memread,
  // branch, jump, memtoreg, regwrite, hilo_write, illegal.
  function automatic logic [14:0] ref_decode(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    logic       rt, ld, st, ai, br, jp, hl;
    int         code;
    op   = ins[31:26];
    fn   = ins[5:0];
    rt   = (op == 6'd0);
    ld   = (op[5:3] == 3'b100);
    st   = (op[5:3] == 3'b101);
    ai   = (op[5:3] == 3'b001);
    br   = (op[5:2] == 4'b0001);
    jp   = (op[5:1] == 5'b00001);
    hl   = is_md(ins);
    code = -1;
    if (rt)            code = r_code(fn);
    else if (ld || st) code = A_ADD;
    else if (ai)       code = i_code(op[2:0]);
    else if (br)       code = A_SUB;
    else if (jp)       code = A_ADD;
    if (code < 0) return {5'(A_ADD), 10'b0000000001};
    return {5'(code), ld | st | ai, rt, st, ld, br, jp, ld, (rt & !hl) | ld | ai, hl, 1'b0};
  endfunction

  function automatic bit m_busy(input int c);
    return (c > md_start) && (c < md_start + md_n);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[31:26] = 6'd0;
      1: begin
        r[31:26] = 6'd0;
        case ($urandom_range(0, 5))
          0:       r[5:0] = 6'd32;
          1:       r[5:0] = 6'd34;
          2:       r[5:0] = 6'd3;
          3:       r[5:0] = 6'd39;
          4:       r[5:0] = 6'd43;
          default: r[5:0] = 6'd8;
        endcase
      end
      2: begin
        r[31:26] = 6'd0;
        case ($urandom_range(0, 5))
          0:       r[5:0] = 6'd16;
          1:       r[5:0] = 6'd18;
          2:       r[5:0] = 6'd24;
          3:       r[5:0] = 6'd25;
          4:       r[5:0] = 6'd26;
          default: r[5:0] = 6'd27;
        endcase
      end
      3: r[31:29] = 3'b100;
      4: r[31:29] = 3'b101;
      5: r[31:29] = 3'b001;
      6: if (r[0]) r[31:28] = 4'b0001; else r[31:27] = 5'b00001;
      default: ;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic checkAll(input logic [31:0] ins, input logic rdy, output logic exp_rdy);
    logic [14:0] got_b;
    exp_rdy = (!m_ov || rdy) && !(m_busy(cyc) && is_hz(ins));
    got_b = {bus.alu_control, bus.alusrc_b, bus.regdst, bus.memwrite, bus.memread,
             bus.branch, bus.jump, bus.memtoreg, bus.regwrite, bus.hilo_write, bus.illegal};
    checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(m_ov));
    checkOutput("md_busy", 32'(bus.md_busy), 32'(m_busy(cyc)));
    checkOutput("bundle", 32'(got_b), 32'(m_bundle));
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy);
    logic exp_rdy;
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.out_ready = rdy;
    @(negedge clk);
    checkAll(ins, rdy, exp_rdy);
    if (v && exp_rdy) begin
      m_bundle = ref_decode(ins);
      m_ov     = 1'b1;
      if (is_md(ins)) begin
        md_start = cyc;
        md_n     = ins[1] ? DIV_N : MUL_N;
      end
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulseReset();
    logic exp_rdy;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b0;
    #2 reset = 1'b1;
    m_ov     = 1'b0;
    m_bundle = '0;
    md_start = -1000;
    #1;
    checkAll(32'h0, 1'b0, exp_rdy);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic exp_rdy;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.instr      = '0;
    bus.out_ready  = 1'b0;
    bus_f.in_valid = 1'b0;
    bus_f.instr    = '0;
    bus_f.out_ready = 1'b0;
    m_ov           = 1'b0;
    m_bundle       = '0;
    md_start       = -1000;
    md_n           = 1;

    @(negedge clk);
    checkAll(32'h0, 1'b0, exp_rdy);
    @(posedge clk);
    #1 reset = 1'b0;

    applyStimulus(1'b1, I_ADDI, 1'b1);
    checkOutput("addi_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("addi_alusrc_b", 32'(bus.alusrc_b), 32'd1);
    checkOutput("addi_regwrite", 32'(bus.regwrite), 32'd1);
    checkOutput("addi_regdst", 32'(bus.regdst), 32'd0);
    checkOutput("addi_alu", 32'(bus.alu_control), 32'(A_ADD));
    checkOutput("addi_illegal", 32'(bus.illegal), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);

    applyStimulus(1'b1, I_LW, 1'b0);
    applyStimulus(1'b1, I_SW, 1'b0);
    checkOutput("lw_memread", 32'(bus.memread), 32'd1);
    checkOutput("lw_memtoreg", 32'(bus.memtoreg), 32'd1);
    checkOutput("lw_in_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, I_SW, 1'b0);
    applyStimulus(1'b1, I_SW, 1'b1);
    checkOutput("sw_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("sw_memwrite", 32'(bus.memwrite), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);

    applyStimulus(1'b1, I_MULT, 1'b1);
    checkOutput("mult_hilo_write", 32'(bus.hilo_write), 32'd1);
    checkOutput("mult_regwrite", 32'(bus.regwrite), 32'd0);
    applyStimulus(1'b1, I_ADD, 1'b1);
    applyStimulus(1'b1, I_MFLO, 1'b1);
    applyStimulus(1'b1, I_MFLO, 1'b1);
    applyStimulus(1'b1, I_MFLO, 1'b1);
    checkOutput("mflo_alu", 32'(bus.alu_control), 32'(A_MFLO));
    applyStimulus(1'b0, 32'h0, 1'b1);

    applyStimulus(1'b1, 32'h04000000, 1'b1);
    checkOutput("ill_op_flag", 32'(bus.illegal), 32'd1);
    checkOutput("ill_op_regwrite", 32'(bus.regwrite), 32'd0);
    applyStimulus(1'b1, 32'h00000001, 1'b1);
    checkOutput("ill_fn_flag", 32'(bus.illegal), 32'd1);
    checkOutput("ill_fn_alu", 32'(bus.alu_control), 32'(A_ADD));
    applyStimulus(1'b0, 32'h0, 1'b1);

    applyStimulus(1'b1, I_DIV, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    pulseReset();
    applyStimulus(1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);

    bus_f.in_valid  = 1'b1;
    bus_f.instr     = I_DIV;
    bus_f.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("fast_div_in_ready", 32'(bus_f.in_ready), 32'd1);
    @(posedge clk);
    #1 bus_f.instr = I_MFHI;
    @(negedge clk);
    checkOutput("fast_md_busy_a", 32'(bus_f.md_busy), 32'd0);
    checkOutput("fast_mfhi_in_ready", 32'(bus_f.in_ready), 32'd1);
    checkOutput("fast_div_alu", 32'(bus_f.alu_control), 32'(A_DIV));
    @(posedge clk);
    #1 bus_f.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("fast_md_busy_b", 32'(bus_f.md_busy), 32'd0);
    checkOutput("fast_out_valid", 32'(bus_f.out_valid), 32'd1);
    checkOutput("fast_mfhi_alu", 32'(bus_f.alu_control), 32'(A_MFHI));
    checkOutput("fast_mfhi_regwrite", 32'(bus_f.regwrite), 32'd1);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
